branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Control-hazard sequencer behind branch_unit in EX. Compares resolved branch/jump outcome with
//  the fetch-time prediction, flushes younger IF/ID work on mispredict, and issues a held PC
//  redirect to fetch over a valid/ready handshake. Traps preempt branch redirects. Also emits
//  predictor training updates and saturating branch/mispredict performance counters.
// PARAMETERS
//  XLEN          32  datapath/address width (riscv_pkg value)
//  DRAIN_CYCLES  1   cycles flush_if stays high after redirect accept (stale fetch squash), 0..7
//  CNT_W         32  perf counter width
// PORTS
//  clk               in   1     clock, rising edge
//  rst_n             in   1     reset, asynchronous, active-low
//  ex_valid          in   1     EX holds a valid instruction
//  ex_is_branch      in   1     EX opcode is OP_BRANCH
//  ex_is_jump        in   1     branch_unit is_jump (JAL/JALR)
//  ex_taken          in   1     branch_unit branch_taken
//  ex_target         in   XLEN  branch_unit branch_target
//  ex_pc             in   XLEN  PC of EX instruction
//  ex_pred_taken     in   1     prediction carried down the pipe
//  ex_pred_target    in   XLEN  predicted target
//  trap_req          in   1     trap/exception redirect request (1-cycle pulse)
//  trap_vector       in   XLEN  trap handler address
//  redirect_valid    out  1     redirect offered to fetch
//  redirect_pc       out  XLEN  redirect address
//  redirect_ready    in   1     fetch accepts redirect
//  flush_if          out  1     kill IF stage contents
//  flush_id          out  1     kill ID stage contents
//  stall_ex          out  1     hold EX/MEM advance while redirect pending
//  misalign_exc      out  1     1-cycle pulse: taken target not 4-byte aligned
//  misalign_addr     out  XLEN  offending target, valid with misalign_exc
//  bp_update_valid   out  1     1-cycle predictor training pulse
//  bp_update_pc      out  XLEN  trained PC
//  bp_update_taken   out  1     actual direction
//  bp_update_target  out  XLEN  actual target
//  perf_branches     out  CNT_W resolved control-flow count
//  perf_mispredicts  out  CNT_W mispredict count
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters 0. Reset mid-HOLD/DRAIN drops redirect immediately.
//  resolve = ex_valid & (ex_is_branch|ex_is_jump) & state==IDLE & ~trap_req. EX inputs ignored otherwise.
//  mispred = (ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target).
//  actual_pc = ex_taken ? ex_target : ex_pc + 4, modulo 2^XLEN (0xFFFF_FFFC+4 -> 0x0).
//  misalign = ex_taken & ex_target[1:0]!=0: registered misalign_exc pulse, no redirect, no
//   mispredict count; perf_branches still increments; bp_update suppressed.
//  On resolve (not misaligned): registered bp_update pulse next cycle; perf_branches+1; if mispred
//   perf_mispredicts+1. Counters saturate at all-ones, never wrap.
//  FSM IDLE: resolve&mispred&~misalign -> flush_if/flush_id combinational same cycle; next cycle
//   HOLD with redirect_pc=actual_pc (latency 1). trap_req -> same, redirect_pc=trap_vector.
//  FSM HOLD: redirect_valid=1, flush_if=flush_id=stall_ex=1; redirect_pc stable until handshake.
//   valid&ready -> DRAIN (count=DRAIN_CYCLES) or IDLE if DRAIN_CYCLES==0; redirect_valid low next cycle.
//  FSM DRAIN: flush_if=1 only, redirect_valid=0, stall_ex=0; decrement; count==1 -> IDLE.
//  trap_req has top priority in every state: next cycle HOLD with redirect_pc=trap_vector, drain
//   count reset. trap_req same cycle as resolve: branch squashed (no counters, no bp_update).
//   trap_req same cycle as HOLD handshake: handshake completes, then trap redirect is re-offered.
// STRUCTURE
//  riscv_pkg: redirect_state_e {RD_IDLE, RD_HOLD, RD_DRAIN}, INSTR_BYTES=4, XLEN.
//  Sub-module sat_counter #(CNT_W) instanced twice (inc, count) for perf counters; FSM, compare,
//  redirect register and bp_update register inline.
// TESTING
//  1 pc=0x80, pred NT, BEQ taken tgt 0x100, ready=1 -> flush same cycle; next cycle
//    redirect_valid=1 pc=0x100; then 1 DRAIN cycle flush_if=1; perf_mispredicts=1, perf_branches=1.
//  2 BNE pred NT, actual NT, pc=0x40 -> no flush/redirect; bp_update pulse pc=0x40 taken=0;
//    perf_branches=1, perf_mispredicts=0.
//  3 mispredict tgt 0x200, redirect_ready low 3 cycles -> redirect_valid, pc=0x200, stall_ex
//    stable; ready on 4th -> accepted, DRAIN, IDLE.
//  4 trap_req vector 0x1000 during HOLD(pc 0x200) -> next cycle redirect_pc=0x1000; trap same
//    cycle as resolve -> counters unchanged.
//  5 JALR taken tgt 0x102 -> misalign_exc pulse addr 0x102, no redirect, perf_branches+1.
//  6 pc=0xFFFF_FFFC pred T actual NT -> redirect_pc=0x0; rst_n low mid-HOLD -> all outputs 0
//    asynchronously; CNT_W=4 after 16 mispredicts -> perf_mispredicts holds 0xF.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared constants for the EX-stage control-hazard sequencer: redirect FSM
// state codes, instruction size and small address helpers.
package branch_redirect_ctrl_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam int DRAIN_W     = 3;

   localparam logic [1:0] RD_IDLE  = 2'd0;
   localparam logic [1:0] RD_HOLD  = 2'd1;
   localparam logic [1:0] RD_DRAIN = 2'd2;

   // Control-flow targets must land on an instruction boundary.
   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb != 2'b00);
   endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat.sv
// Saturating event counter used for the branch and mispredict perf counters;
// sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;

   // Count up on inc unless already saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (inc && !(&count_r)) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-hazard sequencer behind the EX branch unit: detects mispredicts,
// flushes IF/ID, holds a PC redirect for fetch, trains the predictor, counts.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic             trap_req,
   input  logic [XLEN-1:0]  trap_vector,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   input  logic             redirect_ready,
   output logic             flush_if,
   output logic             flush_id,
   output logic             stall_ex,
   output logic             misalign_exc,
   output logic [XLEN-1:0]  misalign_addr,
   output logic             bp_update_valid,
   output logic [XLEN-1:0]  bp_update_pc,
   output logic             bp_update_taken,
   output logic [XLEN-1:0]  bp_update_target,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispredicts
);

   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic [DRAIN_W-1:0] drain_cnt_r;
   logic [DRAIN_W-1:0] drain_cnt_nxt_s;
   logic [XLEN-1:0]    redirect_pc_r;
   logic [XLEN-1:0]    redirect_pc_nxt_s;

   logic               resolve_s;
   logic               misalign_s;
   logic               mispred_s;
   logic               take_redirect_s;
   logic [XLEN-1:0]    actual_pc_s;
   logic               in_hold_s;
   logic               in_drain_s;

   logic               misalign_exc_r;
   logic [XLEN-1:0]    misalign_addr_r;
   logic               bp_valid_r;
   logic [XLEN-1:0]    bp_pc_r;
   logic               bp_taken_r;
   logic [XLEN-1:0]    bp_target_r;

   assign in_hold_s   = (state_r == RD_HOLD);
   assign in_drain_s  = (state_r == RD_DRAIN);

   // EX contents are only looked at when nothing else owns the redirect path.
   assign resolve_s   = ex_valid & (ex_is_branch | ex_is_jump) &
                        (state_r == RD_IDLE) & ~trap_req;
   assign misalign_s  = ex_taken & is_misaligned(ex_target[1:0]);
   assign mispred_s   = (ex_taken != ex_pred_taken) |
                        (ex_taken & (ex_target != ex_pred_target));
   assign actual_pc_s = ex_taken ? ex_target : (ex_pc + XLEN'(INSTR_BYTES));
   assign take_redirect_s = resolve_s & mispred_s & ~misalign_s;

   // Redirect FSM next-state: traps override everything, including drain.
   always_comb begin
      state_nxt_s       = state_r;
      drain_cnt_nxt_s   = drain_cnt_r;
      redirect_pc_nxt_s = redirect_pc_r;
      if (trap_req) begin
         state_nxt_s       = RD_HOLD;
         drain_cnt_nxt_s   = {DRAIN_W{1'b0}};
         redirect_pc_nxt_s = trap_vector;
      end else begin
         case (state_r)
            RD_IDLE: begin
               if (take_redirect_s) begin
                  state_nxt_s       = RD_HOLD;
                  redirect_pc_nxt_s = actual_pc_s;
               end else begin
                  state_nxt_s       = RD_IDLE;
               end
            end
            RD_HOLD: begin
               if (redirect_ready) begin
                  if (DRAIN_INIT == {DRAIN_W{1'b0}}) begin
                     state_nxt_s     = RD_IDLE;
                     drain_cnt_nxt_s = {DRAIN_W{1'b0}};
                  end else begin
                     state_nxt_s     = RD_DRAIN;
                     drain_cnt_nxt_s = DRAIN_INIT;
                  end
               end else begin
                  state_nxt_s = RD_HOLD;
               end
            end
            RD_DRAIN: begin
               if (drain_cnt_r <= {{(DRAIN_W-1){1'b0}}, 1'b1}) begin
                  state_nxt_s     = RD_IDLE;
                  drain_cnt_nxt_s = {DRAIN_W{1'b0}};
               end else begin
                  drain_cnt_nxt_s = drain_cnt_r - {{(DRAIN_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_nxt_s     = RD_IDLE;
               drain_cnt_nxt_s = {DRAIN_W{1'b0}};
            end
         endcase
      end
   end

   // FSM state, drain counter and held redirect address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= RD_IDLE;
         drain_cnt_r   <= {DRAIN_W{1'b0}};
         redirect_pc_r <= {XLEN{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         drain_cnt_r   <= drain_cnt_nxt_s;
         redirect_pc_r <= redirect_pc_nxt_s;
      end
   end

   // Misalignment exception and predictor-training pulses, one cycle after resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_exc_r  <= 1'b0;
         misalign_addr_r <= {XLEN{1'b0}};
         bp_valid_r      <= 1'b0;
         bp_pc_r         <= {XLEN{1'b0}};
         bp_taken_r      <= 1'b0;
         bp_target_r     <= {XLEN{1'b0}};
      end else begin
         misalign_exc_r <= resolve_s & misalign_s;
         bp_valid_r     <= resolve_s & ~misalign_s;
         if (resolve_s & misalign_s) begin
            misalign_addr_r <= ex_target;
         end else begin
            misalign_addr_r <= misalign_addr_r;
         end
         if (resolve_s & ~misalign_s) begin
            bp_pc_r     <= ex_pc;
            bp_taken_r  <= ex_taken;
            bp_target_r <= ex_target;
         end else begin
            bp_pc_r     <= bp_pc_r;
            bp_taken_r  <= bp_taken_r;
            bp_target_r <= bp_target_r;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (resolve_s),
      .count (perf_branches)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (take_redirect_s),
      .count (perf_mispredicts)
   );

   // Flushes assert in the detecting cycle so the wrong-path fetch dies at once.
   assign flush_if         = in_hold_s | in_drain_s | take_redirect_s | trap_req;
   assign flush_id         = in_hold_s | take_redirect_s | trap_req;
   assign stall_ex         = in_hold_s;
   assign redirect_valid   = in_hold_s;
   assign redirect_pc      = redirect_pc_r;
   assign misalign_exc     = misalign_exc_r;
   assign misalign_addr    = misalign_addr_r;
   assign bp_update_valid  = bp_valid_r;
   assign bp_update_pc     = bp_pc_r;
   assign bp_update_taken  = bp_taken_r;
   assign bp_update_target = bp_target_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a transaction-level model predicts
// every output each cycle; literal checks pin the model on the key scenarios.
module tb_branch_redirect_ctrl;

   localparam int DRAIN = 1;

   logic        clk, rst_n;
   logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
   logic [31:0] ex_target, ex_pc, ex_pred_target, trap_vector;
   logic        trap_req, redirect_ready;

   logic        redirect_valid, flush_if, flush_id, stall_ex, misalign_exc;
   logic        bp_update_valid, bp_update_taken;
   logic [31:0] redirect_pc, misalign_addr, bp_update_pc, bp_update_target;
   logic [31:0] perf_branches, perf_mispredicts;

   logic        d4_redirect_valid, d4_flush_if, d4_flush_id, d4_stall_ex, d4_misalign_exc;
   logic        d4_bp_update_valid, d4_bp_update_taken;
   logic [31:0] d4_redirect_pc, d4_misalign_addr, d4_bp_update_pc, d4_bp_update_target;
   logic [3:0]  d4_perf_branches, d4_perf_mispredicts;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model state: an outstanding offer, remaining squash cycles, pending pulses, totals.
   bit          m_offer;
   logic [31:0] m_offer_pc;
   int          m_drain;
   bit          m_mis_pulse, m_bp_pulse, m_bp_taken;
   logic [31:0] m_mis_addr, m_bp_pc, m_bp_tgt;
   longint      m_br, m_mp;

   branch_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .trap_req(trap_req),
      .trap_vector(trap_vector), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .flush_if(flush_if), .flush_id(flush_id),
      .stall_ex(stall_ex), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
      .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
      .bp_update_taken(bp_update_taken), .bp_update_target(bp_update_target),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts));

   branch_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .trap_req(trap_req),
      .trap_vector(trap_vector), .redirect_valid(d4_redirect_valid), .redirect_pc(d4_redirect_pc),
      .redirect_ready(redirect_ready), .flush_if(d4_flush_if), .flush_id(d4_flush_id),
      .stall_ex(d4_stall_ex), .misalign_exc(d4_misalign_exc), .misalign_addr(d4_misalign_addr),
      .bp_update_valid(d4_bp_update_valid), .bp_update_pc(d4_bp_update_pc),
      .bp_update_taken(d4_bp_update_taken), .bp_update_target(d4_bp_update_target),
      .perf_branches(d4_perf_branches), .perf_mispredicts(d4_perf_mispredicts));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] satv(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic bit m_resolve();
      return ex_valid && (ex_is_branch || ex_is_jump) && !m_offer && (m_drain == 0) && !trap_req;
   endfunction

   function automatic bit m_misalign();
      return ex_taken && (ex_target % 32'd4 != 32'd0);
   endfunction

   function automatic bit m_mispred();
      return (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
   endfunction

   // Advance the model by one clock edge from the inputs presented during that cycle.
   task automatic model_update();
      bit res, ma, mp;
      if (!rst_n) begin
         m_offer = 0; m_offer_pc = 32'd0; m_drain = 0; m_mis_pulse = 0; m_bp_pulse = 0;
         m_mis_addr = 32'd0; m_bp_pc = 32'd0; m_bp_taken = 0; m_bp_tgt = 32'd0;
         m_br = 0; m_mp = 0;
      end else begin
         res = m_resolve();
         ma  = m_misalign();
         mp  = m_mispred();
         m_mis_pulse = res && ma;
         if (m_mis_pulse) m_mis_addr = ex_target;
         m_bp_pulse = res && !ma;
         if (m_bp_pulse) begin
            m_bp_pc = ex_pc; m_bp_taken = ex_taken; m_bp_tgt = ex_target;
         end
         if (res) m_br++;
         if (res && !ma && mp) m_mp++;
         if (trap_req) begin
            m_offer = 1; m_offer_pc = trap_vector; m_drain = 0;
         end else if (m_offer) begin
            if (redirect_ready) begin
               m_offer = 0; m_drain = DRAIN;
            end
         end else if (m_drain > 0) begin
            m_drain--;
         end else if (res && mp && !ma) begin
            m_offer = 1;
            m_offer_pc = ex_taken ? ex_target : ex_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_all();
      bit fire;
      fire = m_resolve() && m_mispred() && !m_misalign();
      chk("redirect_valid", redirect_valid, m_offer);
      if (m_offer) chk("redirect_pc", redirect_pc, m_offer_pc);
      chk("stall_ex", stall_ex, m_offer);
      chk("flush_if", flush_if, m_offer || m_drain > 0 || fire || trap_req);
      chk("flush_id", flush_id, m_offer || fire || trap_req);
      chk("misalign_exc", misalign_exc, m_mis_pulse);
      if (m_mis_pulse) chk("misalign_addr", misalign_addr, m_mis_addr);
      chk("bp_update_valid", bp_update_valid, m_bp_pulse);
      if (m_bp_pulse) begin
         chk("bp_update_pc", bp_update_pc, m_bp_pc);
         chk("bp_update_taken", bp_update_taken, m_bp_taken);
         if (m_bp_taken) chk("bp_update_target", bp_update_target, m_bp_tgt);
      end
      chk("perf_branches", perf_branches, satv(m_br, 32));
      chk("perf_mispredicts", perf_mispredicts, satv(m_mp, 32));
      chk("d4_perf_branches", d4_perf_branches, satv(m_br, 4));
      chk("d4_perf_mispredicts", d4_perf_mispredicts, satv(m_mp, 4));
      chk("d4_redirect_valid", d4_redirect_valid, m_offer);
   endtask

   // Single compare process, mid-cycle, against the model.
   always @(negedge clk) begin
      if (chk_en) compare_all();
   end

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic drv(input bit isb, input bit isj, input bit tk, input logic [31:0] tgt,
                      input logic [31:0] pc, input bit pt, input logic [31:0] ptg);
      ex_valid = 1'b1; ex_is_branch = isb; ex_is_jump = isj; ex_taken = tk;
      ex_target = tgt; ex_pc = pc; ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   task automatic clr();
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
      ex_target = 32'd0; ex_pc = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
      trap_req = 1'b0; trap_vector = 32'd0;
   endtask

   initial begin
      rst_n = 1'b0;
      redirect_ready = 1'b0;
      clr();
      repeat (3) tick();
      rst_n = 1'b1;
      at_neg();
      chk("rst redirect_valid", redirect_valid, 1'b0);
      chk("rst redirect_pc", redirect_pc, 32'd0);
      chk("rst flush_if", flush_if, 1'b0);
      chk("rst perf_branches", perf_branches, 32'd0);
      chk_en = 1'b1;
      tick();

      // 1: BEQ taken to 0x100, predicted not-taken, fetch ready.
      redirect_ready = 1'b1;
      drv(1, 0, 1, 32'h100, 32'h80, 0, 32'h0);
      at_neg();
      chk("t1 flush_if same cycle", flush_if, 1'b1);
      chk("t1 flush_id same cycle", flush_id, 1'b1);
      tick(); clr();
      at_neg();
      chk("t1 redirect_valid", redirect_valid, 1'b1);
      chk("t1 redirect_pc", redirect_pc, 32'h100);
      chk("t1 perf_mispredicts", perf_mispredicts, 32'd1);
      chk("t1 perf_branches", perf_branches, 32'd1);
      tick(); at_neg();
      chk("t1 drain flush_if", flush_if, 1'b1);
      chk("t1 drain redirect_valid", redirect_valid, 1'b0);
      tick(); at_neg();
      chk("t1 idle flush_if", flush_if, 1'b0);
      tick();

      // 2: BNE correctly predicted not-taken.
      drv(1, 0, 0, 32'h60, 32'h40, 0, 32'h0);
      at_neg();
      chk("t2 no flush", flush_if, 1'b0);
      tick(); clr();
      at_neg();
      chk("t2 bp_update_valid", bp_update_valid, 1'b1);
      chk("t2 bp_update_pc", bp_update_pc, 32'h40);
      chk("t2 bp_update_taken", bp_update_taken, 1'b0);
      chk("t2 perf_branches", perf_branches, 32'd2);
      chk("t2 perf_mispredicts", perf_mispredicts, 32'd1);
      tick();

      // 3: mispredict to 0x200 with fetch back-pressured for 3 cycles.
      redirect_ready = 1'b0;
      drv(1, 0, 1, 32'h200, 32'h180, 0, 32'h0);
      tick(); clr();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drv(0, 1, 1, 32'h300, 32'h190, 0, 32'h0);
         at_neg();
         chk("t3 hold valid", redirect_valid, 1'b1);
         chk("t3 hold pc", redirect_pc, 32'h200);
         chk("t3 hold stall", stall_ex, 1'b1);
         tick(); clr();
      end
      redirect_ready = 1'b1;
      tick(); at_neg();
      chk("t3 accepted valid", redirect_valid, 1'b0);
      chk("t3 drain flush_if", flush_if, 1'b1);
      tick();

      // 4: trap during HOLD, trap with resolve, trap with handshake.
      redirect_ready = 1'b0;
      drv(1, 0, 1, 32'h200, 32'h1c0, 0, 32'h0);
      tick(); clr();
      trap_req = 1'b1; trap_vector = 32'h1000;
      tick(); clr();
      at_neg();
      chk("t4 trap redirect_pc", redirect_pc, 32'h1000);
      redirect_ready = 1'b1;
      tick(); tick();
      redirect_ready = 1'b0;
      drv(1, 0, 1, 32'h240, 32'h1c4, 0, 32'h0);
      trap_req = 1'b1; trap_vector = 32'h2000;
      tick(); clr();
      at_neg();
      chk("t4 squash perf_branches", perf_branches, 32'd4);
      chk("t4 squash perf_mispredicts", perf_mispredicts, 32'd3);
      chk("t4 squash bp_update", bp_update_valid, 1'b0);
      chk("t4 squash redirect_pc", redirect_pc, 32'h2000);
      redirect_ready = 1'b1;
      trap_req = 1'b1; trap_vector = 32'h3000;
      tick(); clr();
      at_neg();
      chk("t4 reoffer valid", redirect_valid, 1'b1);
      chk("t4 reoffer pc", redirect_pc, 32'h3000);
      tick(); tick();

      // 5: JALR to a misaligned target.
      drv(0, 1, 1, 32'h102, 32'h300, 0, 32'h0);
      at_neg();
      chk("t5 no flush", flush_if, 1'b0);
      tick(); clr();
      at_neg();
      chk("t5 misalign_exc", misalign_exc, 1'b1);
      chk("t5 misalign_addr", misalign_addr, 32'h102);
      chk("t5 perf_branches", perf_branches, 32'd5);
      chk("t5 perf_mispredicts", perf_mispredicts, 32'd3);
      tick();

      // 6: fall-through wraps to 0, then async reset while holding.
      redirect_ready = 1'b0;
      drv(1, 0, 0, 32'h40, 32'hFFFF_FFFC, 1, 32'h40);
      tick(); clr();
      at_neg();
      chk("t6 wrap redirect_pc", redirect_pc, 32'h0);
      chk("t6 wrap valid", redirect_valid, 1'b1);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6 async valid", redirect_valid, 1'b0);
      chk("t6 async stall", stall_ex, 1'b0);
      chk("t6 async flush_id", flush_id, 1'b0);
      chk("t6 async perf_mispredicts", perf_mispredicts, 32'd0);
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // 6b: 17 back-to-back mispredicts saturate the 4-bit counters.
      redirect_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drv(1, 0, 1, 32'h400 + 32'(i) * 32'd8, 32'h500 + 32'(i) * 32'd4, 0, 32'h0);
         tick(); clr();
         tick(); tick();
      end
      at_neg();
      chk("t6 sat d4_perf_mispredicts", d4_perf_mispredicts, 4'hF);
      chk("t6 sat d4_perf_branches", d4_perf_branches, 4'hF);
      chk("t6 wide perf_mispredicts", perf_mispredicts, 32'd17);
      tick();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
